// File: rtl/calc_keypad_pkg.sv
//============================================================================
// calc_keypad_pkg: state encoding and key-code map shared by the keypad
// scanner and the calculator entry logic.             Rev 1.0
//============================================================================
`default_nettype none

package calc_keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESENT  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam int c_KEY_W = 4;

  // Key code is {column, row}; the keypad is wired column-major.
  localparam logic [c_KEY_W-1:0] c_KEY_1   = 4'h0;
  localparam logic [c_KEY_W-1:0] c_KEY_4   = 4'h1;
  localparam logic [c_KEY_W-1:0] c_KEY_7   = 4'h2;
  localparam logic [c_KEY_W-1:0] c_KEY_CLR = 4'h3;
  localparam logic [c_KEY_W-1:0] c_KEY_2   = 4'h4;
  localparam logic [c_KEY_W-1:0] c_KEY_5   = 4'h5;
  localparam logic [c_KEY_W-1:0] c_KEY_8   = 4'h6;
  localparam logic [c_KEY_W-1:0] c_KEY_0   = 4'h7;
  localparam logic [c_KEY_W-1:0] c_KEY_3   = 4'h8;
  localparam logic [c_KEY_W-1:0] c_KEY_6   = 4'h9;
  localparam logic [c_KEY_W-1:0] c_KEY_9   = 4'hA;
  localparam logic [c_KEY_W-1:0] c_KEY_EQ  = 4'hB;
  localparam logic [c_KEY_W-1:0] c_KEY_ADD = 4'hC;
  localparam logic [c_KEY_W-1:0] c_KEY_SUB = 4'hD;
  localparam logic [c_KEY_W-1:0] c_KEY_MUL = 4'hE;
  localparam logic [c_KEY_W-1:0] c_KEY_DIV = 4'hF;

  function automatic logic [c_KEY_W-1:0] key_code(input logic [1:0] col,
                                                   input logic [1:0] row);
    return {col, row};
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan_ctrl_if.sv
//============================================================================
// keypad_scan_ctrl_if: keypad pins plus the key-code valid/ready channel.
//                                                      Rev 1.0
//============================================================================
`default_nettype none

interface keypad_scan_ctrl_if;
  import calc_keypad_pkg::*;

  logic [3:0]         Rows;
  logic [3:0]         Cols;
  logic [c_KEY_W-1:0] KeyCode;
  logic               KeyValid;
  logic               KeyReady;

  modport master (
    input  Rows,
    input  KeyReady,
    output Cols,
    output KeyCode,
    output KeyValid
  );

  modport slave (
    output Rows,
    output KeyReady,
    input  Cols,
    input  KeyCode,
    input  KeyValid
  );

endinterface

`default_nettype wire

// File: rtl/scan_index_counter.sv
//============================================================================
// scan_index_counter: 2-bit wrapping column index with enable.
//                                                      Rev 1.0
//============================================================================
`default_nettype none

module scan_index_counter (
  input  wire logic       Clock,
  input  wire logic       Resetn,
  input  wire logic       i_en,
  output logic [1:0]      o_idx
);

  logic [1:0] r_idx;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_idx <= 2'd0;
    end else if (i_en) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  assign o_idx = r_idx;

endmodule

`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
//============================================================================
// keypad_scan_ctrl: 4x4 keypad scanner with press/release debounce and a
// valid/ready key-code output.                         Rev 1.0
//============================================================================
`default_nettype none

module keypad_scan_ctrl
  import calc_keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 4
) (
  input  wire logic          Clock,
  input  wire logic          Resetn,
  keypad_scan_ctrl_if.master kp
);

  localparam int c_CNT_MAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES
                                                               : SETTLE_CYCLES;
  localparam int c_CNT_W   = ($clog2(c_CNT_MAX + 1) > 5) ? $clog2(c_CNT_MAX + 1) : 5;

  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DEB_LAST    = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

  logic [3:0]         r_sync1;
  logic [3:0]         r_rs;
  kp_state_t          r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_row_idx;
  logic [c_KEY_W-1:0] r_code;
  logic               r_valid;

  logic [1:0]         w_col_idx;
  logic [1:0]         w_row_sel;
  logic               w_row_low;
  logic               w_col_adv;

  scan_index_counter u_col (
    .Clock  (Clock),
    .Resetn (Resetn),
    .i_en   (w_col_adv),
    .o_idx  (w_col_idx)
  );

  // Lowest-numbered low row wins when several rows read low.
  always_comb begin
    casez (r_rs)
      4'b???0: w_row_sel = 2'd0;
      4'b??01: w_row_sel = 2'd1;
      4'b?011: w_row_sel = 2'd2;
      default: w_row_sel = 2'd3;
    endcase
  end

  assign w_row_low = ~r_rs[r_row_idx];

  always_comb begin
    w_col_adv = 1'b0;
    case (r_state)
      SCAN:    w_col_adv = (r_cnt == c_SETTLE_LAST) && (r_rs == 4'hF);
      RELEASE: w_col_adv = !w_row_low && (r_cnt == c_DEB_LAST);
      default: w_col_adv = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_sync1   <= 4'hF;
      r_rs      <= 4'hF;
      r_state   <= SCAN;
      r_cnt     <= '0;
      r_row_idx <= 2'd0;
      r_code    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_sync1 <= kp.Rows;
      r_rs    <= r_sync1;
      case (r_state)
        SCAN: begin
          if (r_cnt == c_SETTLE_LAST) begin
            r_cnt <= '0;
            if (r_rs != 4'hF) begin
              r_row_idx <= w_row_sel;
              r_state   <= DEBOUNCE;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        DEBOUNCE: begin
          if (w_row_low) begin
            if (r_cnt == c_DEB_LAST) begin
              r_code  <= key_code(w_col_idx, r_row_idx);
              r_cnt   <= '0;
              r_state <= PRESENT;
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= SCAN;
          end
        end
        PRESENT: begin
          // Valid rises one cycle after entry; it drops on the handshake edge
          // so the consumer never sees a second beat for the same key.
          if (r_valid && kp.KeyReady) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= RELEASE;
          end else begin
            r_valid <= 1'b1;
          end
        end
        RELEASE: begin
          if (w_row_low) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_cnt   <= '0;
            r_state <= SCAN;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= SCAN;
        end
      endcase
    end
  end

  assign kp.Cols     = ~(4'b0001 << w_col_idx);
  assign kp.KeyCode  = r_code;
  assign kp.KeyValid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
//============================================================================
// tb_keypad_scan_ctrl: directed keypad scenarios with a queue scoreboard.
//                                                      Rev 1.0
//============================================================================
`default_nettype none

module tb_keypad_scan_ctrl;
  import calc_keypad_pkg::*;

  logic Clock;
  logic Resetn;

  keypad_scan_ctrl_if kp ();

  keypad_scan_ctrl #(
    .DEBOUNCE_CYCLES (16),
    .SETTLE_CYCLES   (4)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .kp     (kp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Keypad model: the pressed key pulls its rows low only while its column is driven.
  logic       r_press_en;
  logic [1:0] r_press_col;
  logic [3:0] r_press_rows;
  assign kp.Rows = (r_press_en && !kp.Cols[r_press_col]) ? r_press_rows : 4'hF;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Waits for the cycle on which Cols first switches to the given column.
  task automatic wait_col_start(input string name, input logic [3:0] v);
    logic [3:0] prev;
    logic       hit;
    hit  = 1'b0;
    prev = kp.Cols;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick(1);
      if (kp.Cols == v && prev != v) hit = 1'b1;
      prev = kp.Cols;
    end
    check(name, {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick(1);
      if (kp.KeyValid) hit = 1'b1;
    end
    check(name, {31'd0, hit}, 32'd1);
  endtask

  task automatic press(input logic [1:0] col, input logic [3:0] rows);
    r_press_col  = col;
    r_press_rows = rows;
    r_press_en   = 1'b1;
  endtask

  // Monitor: every handshake must match the oldest expected key.
  always @(negedge Clock) begin
    if (Resetn && kp.KeyValid && kp.KeyReady) begin
      hs_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL hs_unexpected: got code %0h, required no handshake", kp.KeyCode);
      end else begin
        logic [3:0] r_exp;
        r_exp = exp_q.pop_front();
        if (kp.KeyCode !== r_exp) begin
          n_fail++;
          $display("FAIL hs_code: got %0h, required %0h", kp.KeyCode, r_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hs0;
    logic seen_valid;
    logic stable;

    Resetn       = 1'b0;
    r_press_en   = 1'b0;
    r_press_col  = 2'd0;
    r_press_rows = 4'hF;
    kp.KeyReady  = 1'b0;

    // Reset values
    tick(3);
    check("rst_cols", {28'd0, kp.Cols}, 32'hE);
    check("rst_valid", {31'd0, kp.KeyValid}, 32'd0);
    check("rst_code", {28'd0, kp.KeyCode}, 32'h0);

    // Idle sweep: each column held 4 cycles, wrapping 3 -> 0
    Resetn     = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic [1:0] ec;
      logic [3:0] ecols;
      tick(1);
      ec    = 2'(((k + 1) / 4) % 4);
      ecols = ~(4'b0001 << ec);
      check($sformatf("idle_cols_%0d", k), {28'd0, kp.Cols}, {28'd0, ecols});
      if (kp.KeyValid) seen_valid = 1'b1;
    end
    check("idle_no_valid", {31'd0, seen_valid}, 32'd0);

    // Key held in column 0 through reset: KeyValid first high at cycle 20
    Resetn      = 1'b0;
    kp.KeyReady = 1'b1;
    press(2'd0, 4'b1011);
    exp_q.push_back(c_KEY_7);
    hs0 = hs_cnt;
    tick(2);
    Resetn = 1'b1;
    tick(20);
    check("first_valid_c19", {31'd0, kp.KeyValid}, 32'd0);
    tick(1);
    check("first_valid_c20", {31'd0, kp.KeyValid}, 32'd1);
    check("first_code_c20", {28'd0, kp.KeyCode}, {28'd0, c_KEY_7});
    tick(40);
    r_press_en = 1'b0;
    tick(40);
    check("first_one_pulse", hs_cnt - hs0, 32'd1);

    // Col 2 row 1 held 40 cycles: one pulse, code 9
    wait_col_start("wait_col2", 4'b1011);
    hs0 = hs_cnt;
    exp_q.push_back(c_KEY_6);
    press(2'd2, 4'b1101);
    tick(40);
    r_press_en = 1'b0;
    tick(40);
    check("col2_one_pulse", hs_cnt - hs0, 32'd1);

    // Bounce on col 1 row 0: first attempt aborts, later accepted as 4
    wait_col_start("wait_col1_bounce", 4'b1101);
    hs0 = hs_cnt;
    exp_q.push_back(c_KEY_2);
    press(2'd1, 4'b1110);
    tick(5);
    r_press_en = 1'b0;
    tick(1);
    r_press_en = 1'b1;
    tick(3);
    check("bounce_cols_held", {28'd0, kp.Cols}, 32'hD);
    check("bounce_no_valid", {31'd0, kp.KeyValid}, 32'd0);
    tick(21);
    r_press_en = 1'b0;
    tick(40);
    check("bounce_one_pulse", hs_cnt - hs0, 32'd1);

    // KeyReady low for 50 cycles, key released after 10: output stays stable
    kp.KeyReady = 1'b0;
    wait_col_start("wait_col3_stall", 4'b0111);
    hs0 = hs_cnt;
    exp_q.push_back(c_KEY_ADD);
    press(2'd3, 4'b1010);
    wait_valid("stall_valid_rise", 60);
    check("stall_code", {28'd0, kp.KeyCode}, {28'd0, c_KEY_ADD});
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) r_press_en = 1'b0;
      tick(1);
      if (kp.KeyValid !== 1'b1 || kp.KeyCode !== c_KEY_ADD) stable = 1'b0;
    end
    check("stall_stable", {31'd0, stable}, 32'd1);
    check("stall_no_hs", hs_cnt - hs0, 32'd0);
    kp.KeyReady = 1'b1;
    tick(1);
    check("stall_valid_fall", {31'd0, kp.KeyValid}, 32'd0);
    check("stall_one_pulse", hs_cnt - hs0, 32'd1);
    tick(15);
    check("release_cols_h15", {28'd0, kp.Cols}, 32'h7);
    tick(1);
    check("release_cols_h16", {28'd0, kp.Cols}, 32'hE);

    // Two rows low in col 3: lowest row (row 1) wins
    wait_col_start("wait_col3_multi", 4'b0111);
    hs0 = hs_cnt;
    exp_q.push_back(c_KEY_SUB);
    press(2'd3, 4'b0101);
    tick(30);
    r_press_en = 1'b0;
    tick(40);
    check("multi_one_pulse", hs_cnt - hs0, 32'd1);

    // Reset while in PRESENT drops the pending key
    kp.KeyReady = 1'b0;
    wait_col_start("wait_col1_rst", 4'b1101);
    press(2'd1, 4'b1011);
    wait_valid("rstp_valid_rise", 60);
    check("rstp_code", {28'd0, kp.KeyCode}, {28'd0, c_KEY_8});
    Resetn = 1'b0;
    tick(1);
    check("rstp_valid", {31'd0, kp.KeyValid}, 32'd0);
    check("rstp_cols", {28'd0, kp.Cols}, 32'hE);
    check("rstp_code_clr", {28'd0, kp.KeyCode}, 32'h0);
    Resetn     = 1'b1;
    r_press_en = 1'b0;
    tick(5);

    check("queue_empty", exp_q.size(), 32'd0);
    check("total_handshakes", hs_cnt, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
